// File: rtl/ofdm_rx_seq.sv
// ---------------------------------------------------------------------------
// ofdm_rx_seq -- receive sequencer for one OFDM symbol.
//
// Sequence: capture_done -> fft_start ... fft_done -> dem_start ...
// dem_finish -> dem_clear, then back to idle. A successfully decoded frame is
// parked in frame_data behind a valid/ack handshake with the host. Both wait
// stages are guarded by a watchdog that aborts after TIMEOUT cycles.
//
// The FFT-result BSRAM port is shared: the FFT engine writes it, the
// demodulator reads it, and only the current owner's controls reach the RAM.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   capture_done                    1-cycle pulse: sample buffer full
//   fft_start / fft_done            FFT engine start pulse / done pulse
//   dem_start                       demodulator start pulse
//   dem_finish, dem_success,        demodulator result (level, held until
//   dem_res[95:0]                   dem_clear)
//   dem_clear                       1-cycle pulse clearing dem_finish
//   fft_ce, fft_oce, fft_ad[10:0]   FFT engine BSRAM controls
//   dem_ce, dem_oce, dem_ad[10:0]   demodulator BSRAM controls
//   ram_ce, ram_oce, ram_ad[10:0]   muxed BSRAM controls
//   busy                            sequencer not idle
//   frame_valid, frame_data[95:0]   last good frame, unacknowledged
//   frame_ack                       host consumes frame
//   overrun                         sticky: good frame overwrote unacked one
//   timeout_err                     1-cycle pulse on watchdog abort
//   frame_cnt, err_cnt [TW-1:0]     saturating good-frame / error counters
// ---------------------------------------------------------------------------
module ofdm_rx_seq #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_done,
  output logic          fft_start,
  input  logic          fft_done,
  output logic          dem_start,
  input  logic          dem_finish,
  input  logic          dem_success,
  input  logic [95:0]   dem_res,
  output logic          dem_clear,
  input  logic          fft_ce,
  input  logic          fft_oce,
  input  logic [10:0]   fft_ad,
  input  logic          dem_ce,
  input  logic          dem_oce,
  input  logic [10:0]   dem_ad,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic [10:0]   ram_ad,
  output logic          busy,
  output logic          frame_valid,
  output logic [95:0]   frame_data,
  input  logic          frame_ack,
  output logic          overrun,
  output logic          timeout_err,
  output logic [TW-1:0] frame_cnt,
  output logic [TW-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, FFT_WAIT, DEM_WAIT, DEM_DONE} state_e;
  typedef enum logic {OWN_FFT, OWN_DEM} owner_e;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX = '1;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          fft_start_q, fft_start_d;
  logic          dem_start_q, dem_start_d;
  logic          dem_clear_q, dem_clear_d;
  logic          timeout_q, timeout_d;
  logic          frame_valid_q, frame_valid_d;
  logic [95:0]   frame_data_q, frame_data_d;
  logic          overrun_q, overrun_d;
  logic [TW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] err_cnt_q, err_cnt_d;

  logic good_frame;
  logic err_event;

  // Next-state and output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d       = state_q;
    owner_d       = owner_q;
    wd_d          = wd_q;
    fft_start_d   = 1'b0;
    dem_start_d   = 1'b0;
    dem_clear_d   = 1'b0;
    timeout_d     = 1'b0;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    good_frame    = 1'b0;
    err_event     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (capture_done) begin
          state_d     = FFT_WAIT;
          fft_start_d = 1'b1;
          wd_d        = '0;
          owner_d     = OWN_FFT;
        end
      end
      FFT_WAIT: begin
        // A done arriving on the expiry cycle wins over the abort.
        if (fft_done) begin
          state_d     = DEM_WAIT;
          dem_start_d = 1'b1;
          owner_d     = OWN_DEM;
          wd_d        = '0;
        end else if (wd_q == WD_LAST) begin
          state_d     = IDLE;
          owner_d     = OWN_FFT;
          timeout_d   = 1'b1;
          dem_clear_d = 1'b1;
          err_event   = 1'b1;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      DEM_WAIT: begin
        if (dem_finish) begin
          state_d     = DEM_DONE;
          dem_clear_d = 1'b1;
          good_frame  = dem_success;
          err_event   = !dem_success;
        end else if (wd_q == WD_LAST) begin
          state_d     = IDLE;
          owner_d     = OWN_FFT;
          timeout_d   = 1'b1;
          dem_clear_d = 1'b1;
          err_event   = 1'b1;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      DEM_DONE: begin
        state_d = IDLE;
        owner_d = OWN_FFT;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_FFT;
      end
    endcase

    // Host handshake. An ack landing with a new frame consumes the old one,
    // so the new frame is not an overrun.
    if (good_frame) begin
      frame_data_d  = dem_res;
      frame_valid_d = 1'b1;
      if (frame_valid_q && !frame_ack) begin
        overrun_d = 1'b1;
      end else if (frame_valid_q && frame_ack) begin
        overrun_d = 1'b0;
      end
      if (frame_cnt_q != CNT_MAX) begin
        frame_cnt_d = frame_cnt_q + TW'(1);
      end
    end else if (frame_ack && frame_valid_q) begin
      frame_valid_d = 1'b0;
      overrun_d     = 1'b0;
    end

    if (err_event && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + TW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_FFT;
      wd_q          <= '0;
      fft_start_q   <= 1'b0;
      dem_start_q   <= 1'b0;
      dem_clear_q   <= 1'b0;
      timeout_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      owner_q       <= owner_d;
      wd_q          <= wd_d;
      fft_start_q   <= fft_start_d;
      dem_start_q   <= dem_start_d;
      dem_clear_q   <= dem_clear_d;
      timeout_q     <= timeout_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // BSRAM port mux: purely combinational on the owner register so the
  // non-owner can never glitch the RAM controls.
  assign ram_ce  = (owner_q == OWN_DEM) ? dem_ce  : fft_ce;
  assign ram_oce = (owner_q == OWN_DEM) ? dem_oce : fft_oce;
  assign ram_ad  = (owner_q == OWN_DEM) ? dem_ad  : fft_ad;

  assign fft_start   = fft_start_q;
  assign dem_start   = dem_start_q;
  assign dem_clear   = dem_clear_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != IDLE);
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign overrun     = overrun_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ofdm_rx_seq.sv
// ---------------------------------------------------------------------------
// tb_ofdm_rx_seq -- directed bench for ofdm_rx_seq.
// Two instances: dut with the default watchdog for the functional paths, and
// dut_t with TIMEOUT=8 for watchdog expiry. Inputs are driven 1 time unit
// after the rising edge and outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_ofdm_rx_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_done, fft_done, dem_finish, dem_success, frame_ack;
  logic [95:0] dem_res;
  logic        fft_ce, fft_oce, dem_ce, dem_oce;
  logic [10:0] fft_ad, dem_ad;

  logic        fft_start, dem_start, dem_clear, ram_ce, ram_oce, busy;
  logic        frame_valid, overrun, timeout_err;
  logic [10:0] ram_ad;
  logic [95:0] frame_data;
  logic [15:0] frame_cnt, err_cnt;

  logic        cap_t, fftd_t;
  logic        fft_start_t, dem_start_t, dem_clear_t, ram_ce_t, ram_oce_t, busy_t;
  logic        frame_valid_t, overrun_t, timeout_err_t;
  logic [10:0] ram_ad_t;
  logic [95:0] frame_data_t;
  logic [15:0] frame_cnt_t, err_cnt_t;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [95:0] RES_55 = {12{8'h55}};
  localparam logic [95:0] RES_A  = {12{8'hA1}};
  localparam logic [95:0] RES_B  = {12{8'hB2}};
  localparam logic [95:0] RES_C  = {12{8'hC3}};
  localparam logic [95:0] RES_D  = {12{8'hD4}};
  localparam logic [95:0] RES_F  = {12{8'hEE}};

  always #5 clk = ~clk;

  ofdm_rx_seq dut (
    .clk(clk), .rst_n(rst_n), .capture_done(capture_done), .fft_start(fft_start),
    .fft_done(fft_done), .dem_start(dem_start), .dem_finish(dem_finish),
    .dem_success(dem_success), .dem_res(dem_res), .dem_clear(dem_clear),
    .fft_ce(fft_ce), .fft_oce(fft_oce), .fft_ad(fft_ad),
    .dem_ce(dem_ce), .dem_oce(dem_oce), .dem_ad(dem_ad),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_ad(ram_ad), .busy(busy),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_ack(frame_ack),
    .overrun(overrun), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  ofdm_rx_seq #(.TIMEOUT(8), .TW(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .capture_done(cap_t), .fft_start(fft_start_t),
    .fft_done(fftd_t), .dem_start(dem_start_t), .dem_finish(dem_finish),
    .dem_success(dem_success), .dem_res(dem_res), .dem_clear(dem_clear_t),
    .fft_ce(fft_ce), .fft_oce(fft_oce), .fft_ad(fft_ad),
    .dem_ce(dem_ce), .dem_oce(dem_oce), .dem_ad(dem_ad),
    .ram_ce(ram_ce_t), .ram_oce(ram_oce_t), .ram_ad(ram_ad_t), .busy(busy_t),
    .frame_valid(frame_valid_t), .frame_data(frame_data_t), .frame_ack(frame_ack),
    .overrun(overrun_t), .timeout_err(timeout_err_t),
    .frame_cnt(frame_cnt_t), .err_cnt(err_cnt_t)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full symbol on dut; the finish cycle optionally carries a host ack.
  task automatic run_frame(input logic succ, input logic [95:0] res, input logic ack);
    capture_done = 1'b1; step(); capture_done = 1'b0;
    check("rf_fft_start", fft_start, 1);
    repeat (5) step();
    fft_done = 1'b1; step(); fft_done = 1'b0;
    check("rf_dem_start", dem_start, 1);
    repeat (10) step();
    dem_finish = 1'b1; dem_success = succ; dem_res = res; frame_ack = ack;
    step();
    dem_finish = 1'b0; dem_success = 1'b0; frame_ack = 1'b0;
    check("rf_dem_clear", dem_clear, 1);
    step();
    check("rf_idle", busy, 0);
    check("rf_dem_clear_off", dem_clear, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; capture_done = 0; fft_done = 0; dem_finish = 0; dem_success = 0;
    frame_ack = 0; dem_res = '0; fft_ce = 0; fft_oce = 0; dem_ce = 0; dem_oce = 0;
    fft_ad = '0; dem_ad = '0; cap_t = 0; fftd_t = 0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_cnts", {frame_cnt, err_cnt}, 0);
    check("rst_pulses", {dem_start, dem_clear, timeout_err, overrun}, 0);
    rst_n = 1'b1;
    repeat (5) step();

    // ---- good path with mux isolation and ignored capture --------------
    capture_done = 1'b1; step(); capture_done = 1'b0;
    check("gp_fft_start", fft_start, 1);
    check("gp_busy", busy, 1);
    fft_ad = 11'h123; dem_ad = 11'h7FF; fft_ce = 1; fft_oce = 0; dem_ce = 0; dem_oce = 1;
    #1;
    check("mux_fft_ad", ram_ad, 11'h123);
    check("mux_fft_ctl", {ram_ce, ram_oce}, 2'b10);
    dem_ad = 11'h000;
    #1;
    check("mux_fft_iso", ram_ad, 11'h123);
    step();
    check("gp_fft_start_off", fft_start, 0);
    repeat (37) step();
    dem_ad = 11'h7FF; fft_ad = 11'h0AA;
    fft_done = 1'b1; step(); fft_done = 1'b0;
    check("gp_dem_start", dem_start, 1);
    check("mux_dem_ad", ram_ad, 11'h7FF);
    check("mux_dem_ctl", {ram_ce, ram_oce}, 2'b01);
    fft_ad = 11'h555;
    #1;
    check("mux_dem_iso", ram_ad, 11'h7FF);
    step();
    check("gp_dem_start_off", dem_start, 0);
    capture_done = 1'b1; step(); capture_done = 1'b0;
    check("busy_cap_ignored", fft_start, 0);
    step();
    check("busy_cap_ignored2", fft_start, 0);
    repeat (200) step();
    dem_finish = 1'b1; dem_success = 1'b1; dem_res = RES_55;
    step();
    dem_finish = 1'b0; dem_success = 1'b0;
    check("gp_frame_valid", frame_valid, 1);
    check("gp_frame_data", frame_data, RES_55);
    check("gp_dem_clear", dem_clear, 1);
    check("gp_busy_done", busy, 1);
    check("gp_frame_cnt", frame_cnt, 1);
    step();
    check("gp_busy_idle", busy, 0);
    check("gp_dem_clear_off", dem_clear, 0);
    check("gp_owner_back", ram_ad, 11'h555);
    fft_ad = '0; dem_ad = '0; fft_ce = 0; dem_oce = 0;

    // ---- ack, then decode failure --------------------------------------
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    check("ack_valid", frame_valid, 0);
    run_frame(1'b0, RES_F, 1'b0);
    check("fail_valid", frame_valid, 0);
    check("fail_data", frame_data, RES_55);
    check("fail_err_cnt", err_cnt, 1);
    check("fail_frame_cnt", frame_cnt, 1);

    // ---- overrun / ack --------------------------------------------------
    run_frame(1'b1, RES_A, 1'b0);
    check("ov_a_valid", {frame_valid, overrun}, 2'b10);
    run_frame(1'b1, RES_B, 1'b0);
    check("ov_b_data", frame_data, RES_B);
    check("ov_b_overrun", overrun, 1);
    check("ov_b_cnt", frame_cnt, 3);
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    check("ov_ack", {frame_valid, overrun}, 2'b00);
    frame_ack = 1'b1; step(); frame_ack = 1'b0;
    check("ov_ack_idle", {frame_valid, overrun}, 2'b00);
    run_frame(1'b1, RES_C, 1'b0);
    check("ov_c_valid", {frame_valid, overrun}, 2'b10);
    run_frame(1'b1, RES_D, 1'b1);
    check("ov_d_ack_same", {frame_valid, overrun}, 2'b10);
    check("ov_d_data", frame_data, RES_D);
    check("ov_d_cnts", {frame_cnt, err_cnt}, {16'd5, 16'd1});

    // ---- watchdog on dut_t (TIMEOUT=8) ----------------------------------
    cap_t = 1'b1; step(); cap_t = 1'b0;
    check("to_fft_start", fft_start_t, 1);
    repeat (7) step();
    check("to_not_yet", {timeout_err_t, busy_t}, 2'b01);
    step();
    check("to_pulse", timeout_err_t, 1);
    check("to_idle", busy_t, 0);
    check("to_dem_clear", dem_clear_t, 1);
    check("to_err_cnt", err_cnt_t, 1);
    step();
    check("to_pulse_off", timeout_err_t, 0);

    cap_t = 1'b1; step(); cap_t = 1'b0;
    repeat (7) step();
    fftd_t = 1'b1; step(); fftd_t = 1'b0;
    check("to_done_wins", timeout_err_t, 0);
    check("to_done_dem_start", dem_start_t, 1);
    check("to_done_err_cnt", err_cnt_t, 1);
    repeat (7) step();
    check("to_dem_not_yet", {timeout_err_t, busy_t}, 2'b01);
    step();
    check("to_dem_pulse", {timeout_err_t, busy_t}, 2'b10);
    check("to_dem_err_cnt", err_cnt_t, 2);

    // ---- reset in the middle of DEM_WAIT ---------------------------------
    capture_done = 1'b1; step(); capture_done = 1'b0;
    repeat (3) step();
    fft_done = 1'b1; step(); fft_done = 1'b0;
    repeat (3) step();
    fft_ad = 11'h000; dem_ad = 11'h7FF;
    #1;
    check("mr_in_dem", {busy, ram_ad}, {1'b1, 11'h7FF});
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_outputs", {frame_valid, overrun, dem_clear, timeout_err, fft_start, dem_start}, 0);
    check("mr_data", frame_data, 0);
    check("mr_cnts", {frame_cnt, err_cnt}, 0);
    check("mr_owner_fft", ram_ad, 11'h000);
    step();
    check("mr_no_clear", dem_clear, 0);
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ofdm_rx_seq.md
Name: ofdm_rx_seq

Overview:
Top-level receive sequencer for one OFDM symbol. On a capture-complete pulse it starts the FFT, waits for it, then starts the demodulator/decoder and waits for it. It hands a successfully decoded 96-bit frame to the host through a valid/ack register. It also owns the shared FFT-result BSRAM port: the FFT engine (writer) and the demodulator (reader) share it, and only the current owner's controls reach the RAM. It keeps frame and error counters and a watchdog on both stages.

Parameters:
TIMEOUT, 4096, cycle budget per stage (FFT wait, demod wait) before abort; must be >= 2
TW, 16, width of watchdog counter and of the frame/error counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
capture_done  in  1  1-cycle pulse: sample buffer full
fft_start  out  1  1-cycle pulse to FFT engine
fft_done  in  1  1-cycle pulse from FFT engine
dem_start  out  1  1-cycle pulse to demodulator
dem_finish  in  1  level, held until dem_clear
dem_success  in  1  valid while dem_finish=1
dem_res  in  96  decoded frame, valid while dem_finish=1
dem_clear  out  1  1-cycle pulse clearing dem_finish/dem_success
fft_ce, fft_oce  in  1 each  FFT engine BSRAM controls
fft_ad  in  11  FFT engine BSRAM address
dem_ce, dem_oce  in  1 each  demodulator BSRAM controls
dem_ad  in  11  demodulator BSRAM address
ram_ce, ram_oce  out  1 each  muxed BSRAM controls
ram_ad  out  11  muxed BSRAM address
busy  out  1  state != IDLE
frame_valid  out  1  frame_data holds an unacknowledged frame
frame_data  out  96  last good frame
frame_ack  in  1  host consumes frame
overrun  out  1  sticky: good frame overwrote an unacked one
timeout_err  out  1  1-cycle pulse on watchdog abort
frame_cnt  out  TW  good frames, saturating
err_cnt  out  TW  decode failures + timeouts, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, owner=FFT, watchdog 0, frame_data 0.
- States: IDLE, FFT_WAIT, DEM_WAIT, DEM_DONE.
- IDLE: on capture_done at edge N, fft_start=1 during cycle N+1. Enter FFT_WAIT. Watchdog=0, owner=FFT.
- FFT_WAIT: on fft_done, pulse dem_start the next cycle, set owner=DEM in that same cycle, enter DEM_WAIT, watchdog=0.
- DEM_WAIT: on dem_finish=1, enter DEM_DONE.
  - If dem_success: frame_data<=dem_res, frame_valid<=1, frame_cnt+1. If frame_valid was already 1 and not being acked this cycle, overrun<=1.
  - Else: err_cnt+1, frame_data unchanged.
- DEM_DONE: dem_clear=1 for exactly this cycle. Next state IDLE, owner=FFT.
- Watchdog (FFT_WAIT, DEM_WAIT): increments each cycle. When it reaches TIMEOUT-1 with no done/finish that cycle:
  - timeout_err pulse, err_cnt+1, dem_clear pulse (harmless if idle), state IDLE, owner=FFT.
  - A done/finish in the same cycle as expiry wins; no timeout.
- capture_done while busy: ignored, no queuing.
- fft_done outside FFT_WAIT and dem_finish outside DEM_WAIT: ignored.
- BSRAM mux is combinational on the owner register:
  - owner=FFT: ram_*=fft_*.
  - owner=DEM: ram_*=dem_*.
  - The non-owner's controls never reach the RAM.
- Host interface: frame_ack with frame_valid=1 clears frame_valid and overrun next edge. If ack and a new good frame land on the same edge, the new frame is loaded, frame_valid stays 1, and overrun is not set. frame_ack with frame_valid=0: no effect.
- Counters saturate at 2^TW-1. Both increments occur on separate events and never coincide.
- Reset mid-operation: immediate return to reset values; no dem_clear issued.

Test Plan:
- Good path: capture_done at cycle 10, fft_done at 50, dem_finish=1/success=1 with res=0x55..55 at 300 -> fft_start at 11, dem_start at 51, owner switch at 51, frame_valid=1 and frame_data=res at 301, dem_clear at 301, busy=0 at 302, frame_cnt=1.
- Decode fail: same sequence with dem_success=0 -> frame_valid stays 0, err_cnt=1, dem_clear pulses once.
- Timeout: TIMEOUT=8, no fft_done -> timeout_err exactly 8 cycles after fft_start, err_cnt=1, state IDLE. Repeat with fft_done on the expiry cycle -> no timeout, dem_start follows.
- Overrun/ack: two good frames without ack -> second frame_data, overrun=1. Ack -> valid=0, overrun=0. Ack on the same cycle as a new frame -> valid=1, overrun=0.
- Mux isolation: toggle dem_ad=0x7FF during FFT_WAIT -> ram_ad tracks fft_ad only. In DEM_WAIT -> ram_ad tracks dem_ad only.
- Busy/reset: capture_done during DEM_WAIT ignored (single fft_start). Assert rst_n=0 mid DEM_WAIT -> all outputs 0 immediately, counters 0.
